// File: rtl/dcache_control_if.sv
// dcache_control_if: CPU request/response and memory line-transfer handshakes of the cache controller
interface dcache_control_if;
    logic mem_read;
    logic mem_write;
    logic mem_resp;
    logic pmem_read;
    logic pmem_write;
    logic pmem_resp;
    modport master(output mem_read, mem_write, pmem_resp, input mem_resp, pmem_read, pmem_write);
    modport slave(input mem_read, mem_write, pmem_resp, output mem_resp, pmem_read, pmem_write);
endinterface

// File: rtl/dcache_control.sv
// dcache_control: write-back data cache FSM with datapath strobes and saturating hit/miss/writeback counters
module dcache_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    dcache_control_if.slave  bus,
    input  logic             is_hit,
    input  logic             is_dirty,
    output logic             is_allocate,
    output logic             use_replace,
    output logic             load_data,
    output logic             load_tag,
    output logic             load_dirty,
    output logic             load_valid,
    output logic             load_plru,
    output logic             valid_in,
    output logic             dirty_in,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);
    typedef enum logic [2:0] {IDLE, HIT_CHECK, WRITE_BACK, ALLOCATE, REFILL_WAIT} state_t;
    state_t state, next;
    logic retry, set_retry, clr_retry, hit_inc, miss_inc, wb_inc, req;
    assign req = bus.mem_read | bus.mem_write;
    always_comb begin
        next = state;
        bus.mem_resp = 1'b0;
        bus.pmem_read = 1'b0;
        bus.pmem_write = 1'b0;
        is_allocate = 1'b0;
        use_replace = 1'b0;
        load_data = 1'b0;
        load_tag = 1'b0;
        load_dirty = 1'b0;
        load_valid = 1'b0;
        load_plru = 1'b0;
        valid_in = 1'b0;
        dirty_in = 1'b0;
        set_retry = 1'b0;
        clr_retry = 1'b0;
        hit_inc = 1'b0;
        miss_inc = 1'b0;
        wb_inc = 1'b0;
        case (state)
            IDLE: begin
                next = req ? HIT_CHECK : IDLE;
                clr_retry = req;
            end
            HIT_CHECK: begin
                if (!req) next = IDLE;
                else if (is_hit) begin
                    bus.mem_resp = 1'b1;
                    load_plru = 1'b1;
                    load_data = bus.mem_write;
                    load_dirty = bus.mem_write;
                    dirty_in = bus.mem_write;
                    hit_inc = !retry;
                    next = IDLE;
                end else begin
                    miss_inc = 1'b1;
                    next = is_dirty ? WRITE_BACK : ALLOCATE;
                end
            end
            WRITE_BACK: begin
                bus.pmem_write = 1'b1;
                use_replace = 1'b1;
                load_dirty = bus.pmem_resp;
                wb_inc = bus.pmem_resp;
                next = bus.pmem_resp ? ALLOCATE : WRITE_BACK;
            end
            ALLOCATE: begin
                bus.pmem_read = 1'b1;
                use_replace = 1'b1;
                is_allocate = 1'b1;
                load_data = bus.pmem_resp;
                load_tag = bus.pmem_resp;
                load_valid = bus.pmem_resp;
                valid_in = bus.pmem_resp;
                load_dirty = bus.pmem_resp;
                set_retry = bus.pmem_resp;
                next = bus.pmem_resp ? REFILL_WAIT : ALLOCATE;
            end
            REFILL_WAIT: next = HIT_CHECK;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            retry <= 1'b0;
            hit_count <= '0;
            miss_count <= '0;
            wb_count <= '0;
        end else begin
            state <= next;
            retry <= set_retry ? 1'b1 : clr_retry ? 1'b0 : retry;
            if (hit_inc && !(&hit_count)) hit_count <= hit_count + 1'b1;
            if (miss_inc && !(&miss_count)) miss_count <= miss_count + 1'b1;
            if (wb_inc && !(&wb_count)) wb_count <= wb_count + 1'b1;
        end
    end
endmodule
